// File: rtl/pc_trace_buf.sv
// pc_trace_buf: captures qualified supervisor-fetch PCs in a circular buffer.
// The address trigger freezes capture after a post-trigger window. Option: TRACE_TIMESTAMP_EN.
module pc_trace_buf #(
    parameter int DEPTH_LOG2 = 8,
    parameter int PC_W       = 24,
    parameter int POST_W     = 8
) (
    input  logic                  clk12m,
    input  logic                  reset_n,
    input  logic                  cpu_ce,
    input  logic [2:0]            fc,
    input  logic [1:0]            exec_state,
    input  logic                  chk_pc,
    input  logic [PC_W-1:0]       pc,
    input  logic                  arm,
    input  logic                  trig_en,
    input  logic [PC_W-1:0]       trig_addr,
    input  logic [POST_W-1:0]     post_cnt,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [PC_W-1:0]       rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic [1:0]            state,
    output logic                  triggered
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [15:0]           rd_ts
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENT_W = PC_W + 16;
`else
    localparam int ENT_W = PC_W;
`endif
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [POST_W-1:0]     r_post;
    logic [POST_W-1:0]     w_post_nxt;
    logic                  r_trig;
    logic                  w_trig_nxt;
    logic                  w_s;
    logic                  w_hit;
    logic                  w_wr;
    logic [ENT_W-1:0]      r_mem [DEPTH];
    logic [ENT_W-1:0]      w_ent;
    logic [ENT_W-1:0]      r_rd_ent;
    logic                  r_rd_valid;
    logic [DEPTH_LOG2-1:0] w_oldest;
    logic [DEPTH_LOG2-1:0] w_rd_addr;
    logic                  w_rd_in;

    assign w_s   = cpu_ce & (fc == 3'd6) & (exec_state == 2'd1) & chk_pc;
    assign w_hit = trig_en & (pc == trig_addr);

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // arm overrides any same-cycle sample, whatever the state
    always_comb begin
        w_state_nxt = r_state;
        w_post_nxt  = r_post;
        w_trig_nxt  = r_trig;
        w_wr        = 1'b0;
        if (arm) begin
            w_state_nxt = S_ARMED;
            w_post_nxt  = '0;
            w_trig_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                S_ARMED: begin
                    if (w_s) begin
                        w_wr = 1'b1;
                        if (w_hit) begin
                            w_trig_nxt  = 1'b1;
                            w_post_nxt  = post_cnt;
                            w_state_nxt = (post_cnt == '0) ? S_FROZEN : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (w_s) begin
                        w_wr       = 1'b1;
                        w_post_nxt = r_post - 1'b1;
                        if (r_post <= POST_W'(1)) begin
                            w_state_nxt = S_FROZEN;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_post   <= '0;
            r_trig   <= 1'b0;
        end else begin
            r_post <= w_post_nxt;
            r_trig <= w_trig_nxt;
            if (arm) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_count != FULL) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] r_ts;

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            r_ts <= '0;
        end else if (arm) begin
            r_ts <= '0;
        end else if (cpu_ce) begin
            r_ts <= r_ts + 16'd1;
        end
    end

    assign w_ent = {r_ts, pc};
    assign rd_ts = r_rd_ent[ENT_W-1:PC_W];
`else
    assign w_ent = pc;
`endif

    always_ff @(posedge clk12m) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_ent;
        end
    end

    // once wrapped, the slot about to be overwritten holds the oldest entry
    assign w_oldest  = (r_count == FULL) ? r_wr_ptr : '0;
    assign w_rd_addr = w_oldest + rd_idx;
    assign w_rd_in   = ({1'b0, rd_idx} < r_count);

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ent   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_ent <= w_rd_in ? r_mem[w_rd_addr] : '0;
            end
        end
    end

    assign rd_data   = r_rd_ent[PC_W-1:0];
    assign rd_valid  = r_rd_valid;
    assign count     = r_count;
    assign state     = r_state;
    assign triggered = r_trig;

endmodule

// File: tb/tb_pc_trace_buf.sv
// tb_pc_trace_buf: directed and random checks of pc_trace_buf
// against a queue-based model of the trace buffer.
module tb_pc_trace_buf;

    logic        clk12m = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_ce = 1'b0;
    logic [2:0]  fc = 3'd0;
    logic [1:0]  exec_state = 2'd0;
    logic        chk_pc = 1'b0;
    logic [23:0] pc = '0;
    logic        arm = 1'b0;
    logic        trig_en = 1'b0;
    logic [23:0] trig_addr = '0;
    logic [7:0]  post_cnt = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_idx = '0;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic [8:0]  count;
    logic [1:0]  state;
    logic        triggered;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] rd_ts;
`endif

    pc_trace_buf dut (
        .clk12m     (clk12m),
        .reset_n    (reset_n),
        .cpu_ce     (cpu_ce),
        .fc         (fc),
        .exec_state (exec_state),
        .chk_pc     (chk_pc),
        .pc         (pc),
        .arm        (arm),
        .trig_en    (trig_en),
        .trig_addr  (trig_addr),
        .post_cnt   (post_cnt),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .state      (state),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts      (rd_ts),
`endif
        .triggered  (triggered)
    );

    always #5 clk12m = ~clk12m;

    int n_err = 0;
    int n_chk = 0;

    // model: a queue holds {timestamp, pc}, oldest at the front
    logic [39:0] q[$];
    int          m_state;
    int          m_post;
    bit          m_trig;
    logic [15:0] m_ts;
    logic [23:0] m_rd;
    logic [15:0] m_rd_ts;
    bit          m_rv;

    function automatic void m_reset();
        q.delete();
        m_state = 0;
        m_post  = 0;
        m_trig  = 1'b0;
        m_ts    = '0;
        m_rd    = '0;
        m_rd_ts = '0;
        m_rv    = 1'b0;
    endfunction

    function automatic void m_step();
        bit          s;
        logic [15:0] ts_now;
        s = cpu_ce && fc == 3'd6 && exec_state == 2'd1 && chk_pc;
        if (rd_en) begin
            if (int'(rd_idx) < q.size()) {m_rd_ts, m_rd} = q[rd_idx];
            else {m_rd_ts, m_rd} = '0;
            m_rv = 1'b1;
        end else begin
            m_rv = 1'b0;
        end
        ts_now = m_ts;
        if (arm) begin
            q.delete();
            m_state = 1;
            m_trig  = 1'b0;
            m_ts    = '0;
        end else begin
            if (cpu_ce) m_ts = m_ts + 16'd1;
            if (s && (m_state == 1 || m_state == 2)) begin
                q.push_back({ts_now, pc});
                if (q.size() > 256) void'(q.pop_front());
                if (m_state == 1 && trig_en && pc == trig_addr) begin
                    m_trig  = 1'b1;
                    m_post  = int'(post_cnt);
                    m_state = (post_cnt == 0) ? 3 : 2;
                end else if (m_state == 2) begin
                    m_post = m_post - 1;
                    if (m_post == 0) m_state = 3;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("state", 32'(state), 32'(m_state));
        chk("count", 32'(count), 32'(q.size()));
        chk("triggered", 32'(triggered), 32'(m_trig));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        chk("rd_data", 32'(rd_data), 32'(m_rd));
`ifdef TRACE_TIMESTAMP_EN
        chk("rd_ts", 32'(rd_ts), 32'(m_rd_ts));
`endif
    endtask

    task automatic tick();
        m_step();
        @(posedge clk12m);
        #1;
    endtask

    task automatic fetch(input logic [23:0] p);
        cpu_ce = 1'b1; fc = 3'd6; exec_state = 2'd1; chk_pc = 1'b1; pc = p;
        tick(); chk_all();
        cpu_ce = 1'b0;
        tick(); chk_all();
    endtask

    task automatic do_arm();
        arm = 1'b1; tick(); arm = 1'b0; chk_all();
    endtask

    task automatic rdchk(input string tag, input logic [7:0] idx,
                         input logic [23:0] exp);
        rd_en = 1'b1; rd_idx = idx; cpu_ce = 1'b0;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(rd_data), 32'(exp));
        chk_all();
    endtask

    initial begin
        m_reset();
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        reset_n = 1'b1;
        @(posedge clk12m); #1;

        // idle: qualifying fetch must not be captured
        fetch(24'h000400);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_count", 32'(count), 32'd0);
        rdchk("idle_rd", 8'd0, 24'h0);

        // free-run, 10 entries
        trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 10; i++) fetch(24'h100 + 24'(2 * i));
        chk("fr10_count", 32'(count), 32'd10);
        rdchk("fr10_rd0", 8'd0, 24'h000100);
        rdchk("fr10_rd9", 8'd9, 24'h000112);
        rdchk("fr10_rd10", 8'd10, 24'h0);

        // free-run wrap
        do_arm();
        for (int n = 0; n < 300; n++) fetch(24'(2 * n));
        chk("wrap_count", 32'(count), 32'd256);
        chk("wrap_state", 32'(state), 32'd1);
        rdchk("wrap_rd0", 8'd0, 24'h000058);
        rdchk("wrap_rd255", 8'd255, 24'h000256);

        // trigger with post window of 3
        trig_en = 1'b1; trig_addr = 24'h20; post_cnt = 8'd3;
        do_arm();
        for (int p = 'h10; p <= 'h40; p += 2) begin
            fetch(24'(p));
            if (p == 'h24) chk("post_state", 32'(state), 32'd2);
            if (p == 'h26) chk("frz_state", 32'(state), 32'd3);
        end
        chk("trg_state", 32'(state), 32'd3);
        chk("trg_triggered", 32'(triggered), 32'd1);
        chk("trg_count", 32'(count), 32'd12);
        rdchk("trg_last", 8'd11, 24'h000026);
        rdchk("trg_first", 8'd0, 24'h000010);

        // non-qualifying samples at the trigger address
        do_arm();
        for (int k = 0; k < 4; k++) begin
            cpu_ce = (k != 3); fc = (k == 0) ? 3'd5 : 3'd6;
            exec_state = (k == 1) ? 2'd2 : 2'd1;
            chk_pc = (k != 2); pc = 24'h20;
            tick(); chk_all();
        end
        cpu_ce = 1'b0;
        chk("nq_count", 32'(count), 32'd0);
        chk("nq_triggered", 32'(triggered), 32'd0);
        chk("nq_state", 32'(state), 32'd1);

        // freeze immediately, then re-arm against a same-cycle sample
        post_cnt = 8'd0;
        fetch(24'h20);
        chk("p0_state", 32'(state), 32'd3);
        chk("p0_count", 32'(count), 32'd1);
        arm = 1'b1; cpu_ce = 1'b1; fc = 3'd6; exec_state = 2'd1;
        chk_pc = 1'b1; pc = 24'h30;
        tick();
        arm = 1'b0; cpu_ce = 1'b0;
        chk("rearm_state", 32'(state), 32'd1);
        chk("rearm_count", 32'(count), 32'd0);
        chk_all();

        // asynchronous reset in the middle of POST
        post_cnt = 8'd5;
        fetch(24'h20);
        fetch(24'h22);
        chk("mid_post", 32'(state), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        m_reset();
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_trig", 32'(triggered), 32'd0);
        #2 reset_n = 1'b1;
        tick(); chk_all();

        // random traffic
        trig_addr = 24'h20;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                trig_en  = 1'($urandom_range(0, 1));
                post_cnt = 8'($urandom_range(0, 6));
            end
            arm        = ($urandom_range(0, 99) == 0);
            cpu_ce     = 1'($urandom_range(0, 1));
            fc         = ($urandom_range(0, 3) != 0) ? 3'd6 : 3'($urandom_range(0, 7));
            exec_state = ($urandom_range(0, 3) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
            chk_pc     = ($urandom_range(0, 3) != 0);
            pc         = ($urandom_range(0, 7) == 0) ? 24'h20 : 24'($urandom);
            rd_en      = ($urandom_range(0, 2) == 0);
            rd_idx     = 8'($urandom_range(0, 40));
            tick(); chk_all();
        end
        arm = 1'b0; rd_en = 1'b0; cpu_ce = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
